// File: rtl/reg_read.sv
// ============================================================================
// reg_read : bf8b operand-fetch stage with a busy scoreboard and hazard stall.
// Optional: REG_READ_BYPASS_EN forwards the writeback value on the clear edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_read (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   op,
    input  logic [3:0]   dst_addr,
    input  logic [3:0]   src_addr,
    input  logic [127:0] regs,
    input  logic         wb_done,
    input  logic [3:0]   wb_addr,
    input  logic [7:0]   wb_val,
    output logic [1:0]   op_out,
    output logic [3:0]   dst_out,
    output logic [7:0]   dst_val,
    output logic [7:0]   src_val,
    output logic [15:0]  busy,
    output logic         stall,
    output logic         ready
);

    localparam logic [1:0] OP_LOD = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_was_en;
    logic [1:0]  r_op;
    logic [3:0]  r_dst;
    logic [3:0]  r_src;
    logic [15:0] w_clr;
    logic [15:0] w_set;
    logic [15:0] w_view;
    logic        w_hazard;
    logic        w_issue;
    logic        w_capture;
    logic [7:0]  w_dst_val;
    logic [7:0]  w_src_val;

    always_comb begin
        w_clr     = wb_done ? (16'h0001 << wb_addr) : 16'h0000;
`ifdef REG_READ_BYPASS_EN
        w_view    = busy & ~w_clr;
`else
        w_view    = busy;
`endif
        w_hazard  = w_view[r_src] | w_view[r_dst];
        w_capture = en & r_was_en;
        w_next    = r_state;
        w_issue   = 1'b0;
        case (r_state)
            S_IDLE:  if (w_capture) w_next = S_CHECK;
            S_CHECK,
            S_WAIT: begin
                if (w_hazard) begin
                    w_next = S_WAIT;
                end else begin
                    w_issue = 1'b1;
                    w_next  = S_DONE;
                end
            end
            S_DONE:  if (!en) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_set = (w_issue && (r_op == OP_LOD || r_op == OP_ADD))
                ? (16'h0001 << r_dst) : 16'h0000;
        w_dst_val = regs[{r_dst, 3'b000} +: 8];
        w_src_val = regs[{r_src, 3'b000} +: 8];
`ifdef REG_READ_BYPASS_EN
        if (wb_done && wb_addr == r_dst) w_dst_val = wb_val;
        if (wb_done && wb_addr == r_src) w_src_val = wb_val;
`endif
    end

`ifndef REG_READ_BYPASS_EN
    logic w_unused_wb_val;
    assign w_unused_wb_val = ^wb_val;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_was_en <= 1'b0;
            r_op     <= 2'b00;
            r_dst    <= 4'h0;
            r_src    <= 4'h0;
            busy     <= 16'h0000;
            ready    <= 1'b0;
            stall    <= 1'b0;
            op_out   <= 2'b00;
            dst_out  <= 4'h0;
            dst_val  <= 8'h00;
            src_val  <= 8'h00;
        end else begin
            r_was_en <= en;
            ready    <= w_issue;
            // An issue setting the same index that writeback clears must win.
            busy     <= (busy & ~w_clr) | w_set;
            if (r_state == S_IDLE && w_capture) begin
                r_op  <= op;
                r_dst <= dst_addr;
                r_src <= src_addr;
            end
            if (r_state == S_CHECK || r_state == S_WAIT) begin
                stall <= w_hazard;
            end
            if (w_issue) begin
                op_out  <= r_op;
                dst_out <= r_dst;
                dst_val <= w_dst_val;
                src_val <= w_src_val;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_read.sv
// Randomized scoreboard bench for reg_read with a register-file/busy model.
`timescale 1ns/1ps
`default_nettype none

module tb_reg_read;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   op;
    logic [3:0]   dst_addr;
    logic [3:0]   src_addr;
    logic [127:0] regs;
    logic         wb_done;
    logic [3:0]   wb_addr;
    logic [7:0]   wb_val;
    logic [1:0]   op_out;
    logic [3:0]   dst_out;
    logic [7:0]   dst_val;
    logic [7:0]   src_val;
    logic [15:0]  busy;
    logic         stall;
    logic         ready;

    reg_read dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .dst_addr(dst_addr),
        .src_addr(src_addr), .regs(regs), .wb_done(wb_done), .wb_addr(wb_addr),
        .wb_val(wb_val), .op_out(op_out), .dst_out(dst_out), .dst_val(dst_val),
        .src_val(src_val), .busy(busy), .stall(stall), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  dst;
        logic [7:0]  dv;
        logic [7:0]  sv;
        logic [15:0] bsy;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  rf[16];
    logic [15:0] mbusy;
    int          checks = 0;
    int          failures = 0;

`ifdef REG_READ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always_comb begin
        regs = '0;
        for (int i = 0; i < 16; i++) regs[i*8 +: 8] = rf[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit writes(input logic [1:0] o);
        return (o == 2'b01) || (o == 2'b11);
    endfunction

    // Monitor: every ready pulse must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 expected=0 at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                chk("op_out",  {30'd0, op_out},  {30'd0, mon_e.op});
                chk("dst_out", {28'd0, dst_out}, {28'd0, mon_e.dst});
                chk("dst_val", {24'd0, dst_val}, {24'd0, mon_e.dv});
                chk("src_val", {24'd0, src_val}, {24'd0, mon_e.sv});
                chk("busy",    {16'd0, busy},    {16'd0, mon_e.bsy});
            end
        end
    end

    task automatic writeback(input logic [3:0] r, input logic [7:0] v);
        wb_done = 1'b1; wb_addr = r; wb_val = v;
        tick();
        rf[r] = v;
        mbusy[r] = 1'b0;
        wb_done = 1'b0;
    endtask

    // Issue one request; pending writes to its operands are completed by the bench.
    task automatic issue(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s,
                         input bit wbi, input int hold, input bit drop_early);
        exp_t        e;
        logic [7:0]  f[16];
        logic [7:0]  v0, v1;
        logic [15:0] cleared;
        bit          haz, en_low;
        haz = mbusy[s] | mbusy[d];
        en_low = 1'b0;
        en = 1'b1; op = o; dst_addr = d; src_addr = s;
        tick();
        tick();
        e.op = o; e.dst = d;
        if (!haz) begin
            v0 = 8'($urandom);
            if (wbi) begin
                e.dv = BYPASS ? v0 : rf[d];
                e.sv = (s == d) ? e.dv : rf[s];
                e.bsy = (mbusy & ~(16'h1 << d)) | (writes(o) ? (16'h1 << d) : 16'h0);
                wb_done = 1'b1; wb_addr = d; wb_val = v0;
            end else begin
                e.dv = rf[d];
                e.sv = rf[s];
                e.bsy = mbusy | (writes(o) ? (16'h1 << d) : 16'h0);
            end
            q.push_back(e);
            tick();
            if (wbi) begin
                rf[d] = v0;
                wb_done = 1'b0;
            end
            chk("latency_ready", {31'd0, ready}, 32'd1);
        end else begin
            f = rf;
            cleared = 16'h0;
            v0 = 8'($urandom);
            v1 = 8'($urandom);
            if (mbusy[s]) begin f[s] = v0; cleared[s] = 1'b1; end
            if (mbusy[d] && d != s) begin f[d] = v1; cleared[d] = 1'b1; end
            e.dv = f[d];
            e.sv = f[s];
            e.bsy = (mbusy & ~cleared) | (writes(o) ? (16'h1 << d) : 16'h0);
            q.push_back(e);
            for (int k = 0; k < $urandom_range(1, 3); k++) begin
                tick();
                chk("stall_high", {31'd0, stall}, 32'd1);
                chk("no_ready_while_busy", {31'd0, ready}, 32'd0);
                if (drop_early) begin en = 1'b0; en_low = 1'b1; end
            end
            if (mbusy[s]) writeback(s, v0);
            if (mbusy[d]) writeback(d, v1);
            if (!BYPASS) begin
                chk("ready_waits_after_clear", {31'd0, ready}, 32'd0);
                tick();
            end
            chk("ready_after_clear", {31'd0, ready}, 32'd1);
            chk("stall_released", {31'd0, stall}, 32'd0);
        end
        mbusy = e.bsy;
        if (!en_low) begin
            for (int k = 0; k < hold; k++) tick();
            en = 1'b0;
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
        mbusy = 16'h0;
        rst_n = 1'b0; en = 1'b0; op = 2'b00; dst_addr = 4'h0; src_addr = 4'h0;
        wb_done = 1'b0; wb_addr = 4'h0; wb_val = 8'h00;
        tick();
        tick();
        chk("rst_busy",    {16'd0, busy},    32'd0);
        chk("rst_ready",   {31'd0, ready},   32'd0);
        chk("rst_stall",   {31'd0, stall},   32'd0);
        chk("rst_op_out",  {30'd0, op_out},  32'd0);
        chk("rst_dst_out", {28'd0, dst_out}, 32'd0);
        chk("rst_dst_val", {24'd0, dst_val}, 32'd0);
        chk("rst_src_val", {24'd0, src_val}, 32'd0);
        rst_n = 1'b1;
        tick();

        rf[3] = 8'h5A; rf[7] = 8'hC3;
        issue(2'b11, 4'd3, 4'd7, 1'b0, 0, 1'b0);
        chk("busy_after_add", {16'd0, busy}, 32'h0008);
        issue(2'b10, 4'd5, 4'd0, 1'b0, 0, 1'b0);
        chk("busy5_clear", {31'd0, busy[5]}, 32'd0);
        issue(2'b00, 4'd1, 4'd3, 1'b0, 0, 1'b0);
        issue(2'b01, 4'd6, 4'd2, 1'b0, 10, 1'b0);
        issue(2'b11, 4'd8, 4'd8, 1'b0, 0, 1'b0);
        // Non-pending writeback is harmless; same-edge set on dst wins.
        writeback(4'd12, 8'h77);
        issue(2'b11, 4'd4, 4'd4, 1'b1, 0, 1'b0);
        chk("set_wins", {31'd0, busy[4]}, 32'd1);
        issue(2'b11, 4'd4, 4'd9, 1'b0, 0, 1'b1);

        // Reset while waiting on a busy operand.
        en = 1'b1; op = 2'b01; dst_addr = 4'd2; src_addr = 4'd6;
        tick(); tick(); tick(); tick();
        chk("wait_before_reset", {31'd0, stall}, 32'd1);
        rst_n = 1'b0; en = 1'b0;
        tick();
        rst_n = 1'b1;
        mbusy = 16'h0;
        chk("rst_wait_busy",  {16'd0, busy},  32'd0);
        chk("rst_wait_ready", {31'd0, ready}, 32'd0);
        chk("rst_wait_stall", {31'd0, stall}, 32'd0);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_after_reset", {31'd0, ready}, 32'd0);
        end

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [3:0] r;
                r = 4'($urandom);
                for (int i = 0; i < 16; i++) if (mbusy[i] && $urandom_range(0, 1) == 1) r = 4'(i);
                writeback(r, 8'($urandom));
            end
            issue(2'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
        end

        tick(); tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
